// File: rtl/adam_aes_encipher_stream_if.sv
// ---------------------------------------------------------------------------
// adam_aes_encipher_stream_if
// Streaming bus of the pipelined AES encipher core.
//   in_valid/in_ready/in_block/in_tag     : plaintext request channel
//   out_valid/out_ready/out_block/out_tag : ciphertext response channel
// Modports:
//   master : the environment (drives requests, accepts responses)
//   slave  : the core
// TAG_W must match the TAG_W of the core it connects to.
// ---------------------------------------------------------------------------
interface adam_aes_encipher_stream_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_block;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_block;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_block, in_tag, out_ready,
        input  in_ready, out_valid, out_block, out_tag
    );

    modport slave (
        input  in_valid, in_block, in_tag, out_ready,
        output in_ready, out_valid, out_block, out_tag
    );
endinterface

// File: rtl/adam_aes_encipher_stream.sv
// ---------------------------------------------------------------------------
// adam_aes_encipher_stream
// Fully pipelined AES-128/AES-256 encipher with valid/ready streaming,
// per-stage valid bits and bubble-collapsing backpressure. A user tag rides
// along with every block.
//
// Parameters:
//   NR    : rounds, 10 (AES-128) or 14 (AES-256)
//   RPS   : rounds per pipeline stage, 1 or 2
//   TAG_W : sideband tag width, 1..32
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   strm         : streaming bus (slave modport), see the interface file
//   round_keys   : expanded schedule, [0] is the whitening key; must be
//                  held stable while busy
//   flush        : synchronous clear of every stage valid bit
//   busy         : some stage holds a valid block
// Optional (macro ADAM_AES_STREAM_STATS_EN):
//   blk_in_cnt, blk_out_cnt, stall_cnt : free-running 32-bit counters of
//   input handshakes, output handshakes and stalled output cycles.
//
// Stage 0 holds in_block ^ round_keys[0]; stages 1..STAGES each apply RPS
// rounds, the very last round skipping MixColumns.
// ---------------------------------------------------------------------------

// One AES round: SubBytes, ShiftRows, MixColumns (unless final), AddRoundKey.
// Byte i of the state is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
module adam_aes_round_module #(
    parameter bit IS_FINAL_ROUND = 1'b0
) (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box as inverse (x^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        inv  = gmul(gmul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes and ShiftRows fused: output row r, column c takes column c+r.
    function automatic logic [127:0] sub_shift(input logic [127:0] st);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(st[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    logic [127:0] sr;
    logic [127:0] mc;

    assign sr = sub_shift(state_in);

    if (IS_FINAL_ROUND) begin : g_final
        assign mc = sr;
    end else begin : g_mix
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
        end
    end

    assign state_out = mc ^ round_key;
endmodule

module adam_aes_encipher_stream #(
    parameter int NR    = 10,
    parameter int RPS   = 1,
    parameter int TAG_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    adam_aes_encipher_stream_if.slave strm,
    input  logic [NR:0][127:0]  round_keys,
    input  logic                flush,
    output logic                busy
`ifdef ADAM_AES_STREAM_STATS_EN
    ,
    output logic [31:0]         blk_in_cnt,
    output logic [31:0]         blk_out_cnt,
    output logic [31:0]         stall_cnt
`endif
);
    // Index of the last stage; the pipeline has STAGES+1 stages.
    localparam int STAGES = NR / RPS;

    if (NR != 10 && NR != 14) begin : g_bad_nr
        $error("adam_aes_encipher_stream: NR must be 10 or 14");
    end
    if (RPS != 1 && RPS != 2) begin : g_bad_rps
        $error("adam_aes_encipher_stream: RPS must be 1 or 2");
    end
    if (TAG_W < 1 || TAG_W > 32) begin : g_bad_tag
        $error("adam_aes_encipher_stream: TAG_W must be 1..32");
    end

    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0][127:0]      data_q;
    logic [STAGES:0][TAG_W-1:0]  tag_q;

    logic [STAGES:0]             adv;
    logic [STAGES:0]             src_vld;
    logic [STAGES:0][127:0]      nxt_data;
    logic [STAGES:0][TAG_W-1:0]  nxt_tag;
    logic                        in_rdy;

    // A stage may advance when it is empty or the stage after it advances,
    // so bubbles are squeezed out while the output is stalled.
    always_comb begin
        adv         = '0;
        adv[STAGES] = !vld_pipe[STAGES] | strm.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !vld_pipe[k] | adv[k+1];
        end
    end

    assign in_rdy        = adv[0] & !flush;
    assign src_vld       = {vld_pipe[STAGES-1:0], strm.in_valid & !flush};
    assign nxt_tag       = {tag_q[STAGES-1:0], strm.in_tag};
    assign nxt_data[0]   = strm.in_block ^ round_keys[0];

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        logic [RPS:0][127:0] chain;
        assign chain[0] = data_q[k-1];
        for (genvar r = 0; r < RPS; r++) begin : g_rnd
            localparam int RI = (k - 1) * RPS + r + 1;
            adam_aes_round_module #(
                .IS_FINAL_ROUND(RI == NR)
            ) u_round (
                .state_in (chain[r]),
                .round_key(round_keys[RI]),
                .state_out(chain[r+1])
            );
        end
        assign nxt_data[k] = chain[RPS];
    end

    // Flush only drops valid bits; data registers load only real blocks so
    // the output holds its last value across bubbles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            data_q   <= '0;
            tag_q    <= '0;
        end else begin
            for (int k = 0; k <= STAGES; k++) begin
                if (flush) begin
                    vld_pipe[k] <= 1'b0;
                end else if (adv[k]) begin
                    vld_pipe[k] <= src_vld[k];
                end
                if (adv[k] && src_vld[k]) begin
                    data_q[k] <= nxt_data[k];
                    tag_q[k]  <= nxt_tag[k];
                end
            end
        end
    end

    assign strm.in_ready  = in_rdy;
    assign strm.out_valid = vld_pipe[STAGES];
    assign strm.out_block = data_q[STAGES];
    assign strm.out_tag   = tag_q[STAGES];
    assign busy           = |vld_pipe;

`ifdef ADAM_AES_STREAM_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_in_cnt  <= '0;
            blk_out_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (strm.in_valid && in_rdy) blk_in_cnt <= blk_in_cnt + 32'd1;
            if (vld_pipe[STAGES] && strm.out_ready) blk_out_cnt <= blk_out_cnt + 32'd1;
            if (vld_pipe[STAGES] && !strm.out_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_adam_aes_encipher_stream.sv
// ---------------------------------------------------------------------------
// tb_adam_aes_encipher_stream
// Directed bench: dut_a is AES-128 with one round per stage (11 stages),
// dut_b is AES-256 with two rounds per stage (8 stages). Inputs change 1ns
// after the rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_adam_aes_encipher_stream;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk;
    logic reset_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    adam_aes_encipher_stream_if #(.TAG_W(8)) ia ();
    adam_aes_encipher_stream_if #(.TAG_W(8)) ib ();

    logic [14:0][127:0] rk_a;
    logic [14:0][127:0] rk_b;
    logic flush_a, flush_b, busy_a, busy_b;
`ifdef ADAM_AES_STREAM_STATS_EN
    logic [31:0] bin_a, bout_a, stall_a, bin_b, bout_b, stall_b;
`endif

    adam_aes_encipher_stream #(.NR(10), .RPS(1), .TAG_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .strm(ia), .round_keys(rk_a[10:0]),
        .flush(flush_a), .busy(busy_a)
`ifdef ADAM_AES_STREAM_STATS_EN
        , .blk_in_cnt(bin_a), .blk_out_cnt(bout_a), .stall_cnt(stall_a)
`endif
    );

    adam_aes_encipher_stream #(.NR(14), .RPS(2), .TAG_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .strm(ib), .round_keys(rk_b),
        .flush(flush_b), .busy(busy_b)
`ifdef ADAM_AES_STREAM_STATS_EN
        , .blk_in_cnt(bin_b), .blk_out_cnt(bout_b), .stall_cnt(stall_b)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] sbox_tb [256];

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box table from the generator-3 walk (p *= 3, q /= 3 each step).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tb[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr,
                              output logic [14:0][127:0] rk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        rk = '0;
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input int nr,
                                               input logic [14:0][127:0] rk);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] st;
        st = pt ^ rk[0];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tb[st[127-8*i -: 8]];
            for (int i = 0; i < 16; i++) t[i] = s[(i + 4 * (i % 4)) % 16];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = t[i];
            st = st ^ rk[r];
        end
        return st;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one block, then watch 25 cycles; lat is the cycle of the first
    // out_valid counted from the handshake cycle, nv the number of valid cycles.
    task automatic one_block(input bit use_b, input logic [127:0] pt, input logic [7:0] tg,
                             output int lat, output logic [127:0] blk,
                             output logic [7:0] otag, output int nv);
        lat = -1; blk = '0; otag = '0; nv = 0;
        if (use_b) begin ib.in_valid = 1'b1; ib.in_block = pt; ib.in_tag = tg; end
        else       begin ia.in_valid = 1'b1; ia.in_block = pt; ia.in_tag = tg; end
        #4;
        chk("handshake_ready", use_b ? ib.in_ready : ia.in_ready, 1);
        for (int c = 1; c <= 25; c++) begin
            tick();
            ia.in_valid = 1'b0;
            ib.in_valid = 1'b0;
            #4;
            if (use_b ? ib.out_valid : ia.out_valid) begin
                nv++;
                if (lat < 0) begin
                    lat  = c;
                    blk  = use_b ? ib.out_block : ia.out_block;
                    otag = use_b ? ib.out_tag : ia.out_tag;
                end
            end
        end
        tick();
    endtask

    initial begin
        logic [127:0] blk, hold, pt;
        logic [7:0]   tg;
        logic [127:0] exp_q [$];
        logic [7:0]   tag_q [$];
        int lat, nv, acc, nout, first, last, rdy_drop, spurious, stall_cyc, bad_hold, held;
`ifdef ADAM_AES_STREAM_STATS_EN
        logic [31:0] stall0;
`endif

        build_sbox();
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10, rk_a);
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, rk_b);

        ia.in_valid = 1'b0; ia.in_block = '0; ia.in_tag = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.in_block = '0; ib.in_tag = '0; ib.out_ready = 1'b1;
        flush_a = 1'b0; flush_b = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        #4;
        // Reset state
        chk("rst_a_out_valid", ia.out_valid, 0);
        chk("rst_a_out_block", ia.out_block, 0);
        chk("rst_a_out_tag",   ia.out_tag, 0);
        chk("rst_a_busy",      busy_a, 0);
        chk("rst_a_in_ready",  ia.in_ready, 1);
        chk("rst_b_out_valid", ib.out_valid, 0);
        chk("rst_b_out_block", ib.out_block, 0);
        chk("rst_b_out_tag",   ib.out_tag, 0);
        chk("rst_b_busy",      busy_b, 0);
        chk("rst_b_in_ready",  ib.in_ready, 1);
`ifdef ADAM_AES_STREAM_STATS_EN
        chk("rst_bin", bin_a, 0);
        chk("rst_bout", bout_a, 0);
        chk("rst_stall", stall_a, 0);
`endif
        tick();
        reset_n = 1'b1;
        tick();

        // FIPS-197 C.1 and C.3
        one_block(1'b0, PT, 8'h5a, lat, blk, tg, nv);
        chk("c1_latency", lat, 11);
        chk("c1_block", blk, C1);
        chk("c1_tag", tg, 8'h5a);
        chk("c1_single_out", nv, 1);
        one_block(1'b1, PT, 8'hb7, lat, blk, tg, nv);
        chk("c3_latency", lat, 8);
        chk("c3_block", blk, C3);
        chk("c3_tag", tg, 8'hb7);
        chk("c3_single_out", nv, 1);

        // Streaming: 100 back-to-back blocks
        acc = 0; nout = 0; first = -1; last = -1; rdy_drop = 0; spurious = 0;
        for (int c = 0; c < 400 && nout < 100; c++) begin
            if (acc < 100) begin
                pt = rnd128();
                ia.in_valid = 1'b1; ia.in_block = pt; ia.in_tag = 8'(acc);
            end else begin
                ia.in_valid = 1'b0;
            end
            #4;
            if (ia.in_valid) begin
                if (!ia.in_ready) rdy_drop++;
                else begin
                    exp_q.push_back(aes_model(ia.in_block, 10, rk_a));
                    tag_q.push_back(ia.in_tag);
                    acc++;
                end
            end
            if (ia.out_valid) begin
                if (exp_q.size() == 0) spurious++;
                else begin
                    chk("stream_block", ia.out_block, exp_q.pop_front());
                    chk("stream_tag", ia.out_tag, tag_q.pop_front());
                end
                if (first < 0) first = c;
                last = c;
                nout++;
            end
            tick();
        end
        ia.in_valid = 1'b0;
        chk("stream_count", nout, 100);
        chk("stream_ready_drops", rdy_drop, 0);
        chk("stream_consecutive", last - first, 99);
        chk("stream_spurious", spurious, 0);
        chk("stream_first_latency", first, 11);

        // Backpressure with input bubbles at cycles 1 and 5
        acc = 0; stall_cyc = 0; bad_hold = 0; held = 0; nout = 0;
        hold = '0;
`ifdef ADAM_AES_STREAM_STATS_EN
        stall0 = stall_a;
`endif
        for (int c = 0; c < 40; c++) begin
            ia.out_ready = (c < 3);
            ia.in_valid  = (c != 1 && c != 5);
            ia.in_block  = rnd128();
            ia.in_tag    = 8'(c + 100);
            #4;
            if (ia.in_valid && ia.in_ready) begin
                exp_q.push_back(aes_model(ia.in_block, 10, rk_a));
                tag_q.push_back(ia.in_tag);
                acc++;
            end
            if (ia.out_valid && ia.out_ready) nout++;
            if (ia.out_valid && !ia.out_ready) begin
                stall_cyc++;
                if (held == 0) begin hold = ia.out_block; held = 1; end
                else if (ia.out_block !== hold) bad_hold++;
            end
            tick();
        end
        chk("bp_accepted", acc, 11);
        chk("bp_early_pops", nout, 0);
        chk("bp_in_ready_low", ia.in_ready, 0);
        chk("bp_busy", busy_a, 1);
        chk("bp_held_seen", held, 1);
        chk("bp_hold_stable", bad_hold, 0);
        chk("bp_stall_cycles", stall_cyc, 29);
`ifdef ADAM_AES_STREAM_STATS_EN
        chk("bp_stall_cnt", stall_a - stall0, 29);
`endif
        ia.in_valid = 1'b0;
        ia.out_ready = 1'b1;
        nout = 0; spurious = 0;
        for (int c = 0; c < 40; c++) begin
            #4;
            if (ia.out_valid) begin
                if (exp_q.size() == 0) spurious++;
                else begin
                    chk("drain_block", ia.out_block, exp_q.pop_front());
                    chk("drain_tag", ia.out_tag, tag_q.pop_front());
                end
                nout++;
            end
            tick();
        end
        chk("drain_count", nout, 11);
        chk("drain_spurious", spurious, 0);
        chk("drain_busy", busy_a, 0);

        // Flush with 5 blocks in flight
        for (int c = 0; c < 5; c++) begin
            ia.in_valid = 1'b1; ia.in_block = rnd128(); ia.in_tag = 8'(200 + c);
            #4;
            chk("flush_fill_ready", ia.in_ready, 1);
            tick();
        end
        flush_a = 1'b1;
        ia.in_block = rnd128();
        #4;
        chk("flush_in_ready_forced", ia.in_ready, 0);
        tick();
        flush_a = 1'b0;
        ia.in_valid = 1'b0;
        #4;
        chk("flush_busy_cleared", busy_a, 0);
        chk("flush_out_valid", ia.out_valid, 0);
        tick();
        nv = 0;
        for (int c = 0; c < 15; c++) begin
            #4;
            if (ia.out_valid) nv++;
            tick();
        end
        chk("flush_no_output", nv, 0);
        one_block(1'b0, PT, 8'hc3, lat, blk, tg, nv);
        chk("post_flush_latency", lat, 11);
        chk("post_flush_block", blk, C1);
        chk("post_flush_tag", tg, 8'hc3);
        chk("post_flush_single", nv, 1);
`ifdef ADAM_AES_STREAM_STATS_EN
        chk("stats_in_total", bin_a, 118);
        chk("stats_flushed", bin_a - bout_a, 5);
`endif

        // Reset with 7 blocks in flight
        for (int c = 0; c < 7; c++) begin
            ia.in_valid = 1'b1; ia.in_block = rnd128(); ia.in_tag = 8'(c);
            tick();
        end
        ia.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", ia.out_valid, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_in_ready", ia.in_ready, 1);
        chk("mid_rst_out_block", ia.out_block, 0);
`ifdef ADAM_AES_STREAM_STATS_EN
        chk("mid_rst_bin", bin_a, 0);
        chk("mid_rst_bout", bout_a, 0);
        chk("mid_rst_stall", stall_a, 0);
`endif
        tick();
        reset_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 15; c++) begin
            #4;
            if (ia.out_valid || busy_a) nv++;
            tick();
        end
        chk("mid_rst_no_output", nv, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adam_aes_encipher_stream.md
Name: adam_aes_encipher_stream

Overview:
Parametrised, fully pipelined AES encipher core with a valid/ready streaming interface, per-stage valid tracking and bubble-collapsing backpressure. Supports AES-128 and AES-256 (NR = 10 or 14) and a selectable register density. Carries a user tag alongside each block. It sits between the AES peripheral's key-expansion/register front-end and its output FIFO, and instantiates adam_aes_round_module once per round.

Parameters:
NR, 10, number of AES rounds; legal values are 10 (AES-128) and 14 (AES-256); any other value is an elaboration error.
RPS, 1, rounds per pipeline stage; legal values are 1 and 2; with 2, two round modules are chained combinationally between registers.
TAG_W, 8, width of the sideband tag carried with each block; legal range is 1 to 32.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  input block offered
in_ready  out  1  core accepts the block this cycle
in_block  in  128  plaintext
in_tag  in  TAG_W  sideband tag
round_keys  in  (NR+1)x128  expanded keys; index 0 is the whitening key
out_valid  out  1  ciphertext available
out_ready  in  1  downstream accepts
out_block  out  128  ciphertext
out_tag  out  TAG_W  tag of out_block
flush  in  1  synchronous pipeline clear
busy  out  1  at least one stage holds a valid block

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Stage layout:
  - Stage 0 registers in_block ^ round_keys[0].
  - Stages 1 to S-1, with S = 1 + NR/RPS, each apply RPS rounds.
  - The last round of stage S-1 uses IS_FINAL_ROUND=1 (no MixColumns).
  - S = 11, 6, 15 or 8.
- Per-stage state: each stage k holds a data register, a tag register and a valid bit v[k].
- Advance rule:
  - adv[S-1] = !v[S-1] | out_ready.
  - adv[k] = !v[k] | adv[k+1].
  - Stage k loads from stage k-1 when adv[k]; v[k] <= v[k-1] & adv[k] ? 1 : (adv[k] ? 0 : v[k]).
  - Stalled stages hold data, tag and valid.
- Input side: in_ready = adv[0]. A transfer occurs when in_valid & in_ready.
- Output side:
  - out_valid = v[S-1]; out_block and out_tag are driven directly from the stage S-1 registers.
  - out_block and out_tag are stable while out_valid & !out_ready.
- Latency and throughput:
  - Latency is exactly S cycles from the input handshake to out_valid when unstalled (AES-128 with RPS=1: 11 cycles).
  - Throughput is 1 block/cycle with out_ready held high.
- Bubbles: internal bubbles collapse under backpressure, so the pipeline reaches full occupancy S before in_ready drops.
- Ordering: blocks leave in acceptance order; each tag stays aligned with its block.
- Keys: round_keys must be stable while busy=1. The verification environment asserts this; the core does not latch keys.
- flush:
  - All v[k] clear on the next edge; data registers are not cleared.
  - in_ready is forced 0 during the flush cycle, so no input is accepted in that cycle.
  - flush has priority over every advance.
- busy = |v.
- Reset values: every v[k] = 0, data and tags = 0. As a result out_valid=0, out_block=0, out_tag=0, busy=0 and in_ready=1.
- Reset mid-stream: an assertion of reset_n discards all in-flight blocks. No output is produced for them.
- Simultaneous events:
  - A pop at the output and a push at the input in the same cycle with a full pipeline is legal; occupancy stays S.
  - flush together with in_valid drops the offered block (in_ready=0).

Optional Feature:
Macro ADAM_AES_STREAM_STATS_EN.
- Defined:
  - Adds output ports blk_in_cnt [31:0], blk_out_cnt [31:0] and stall_cnt [31:0].
  - blk_in_cnt counts input handshakes and blk_out_cnt counts output handshakes.
  - stall_cnt counts cycles with out_valid & !out_ready.
  - All three wrap at 2^32 and reset to 0.
  - flush does not clear the counters.
  - Blocks discarded by flush are counted in blk_in_cnt and never in blk_out_cnt.
- Undefined: the ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- FIPS-197 C.1, NR=10, RPS=1: key 000102..0f expanded; in_block 00112233445566778899aabbccddeeff, tag 0x5A -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_tag 0x5A, out_valid exactly 11 cycles after the handshake.
- FIPS-197 C.3, NR=14, RPS=2: key 000102..1f; same plaintext -> 8ea2b7ca516745bfeafc49904b496089 after 8 cycles.
- Streaming: 100 back-to-back random blocks with out_ready=1 -> in_ready stays 1, outputs on 100 consecutive cycles, in order, matching a reference model, tags 0..99 aligned.
- Backpressure: out_ready=0 from cycle 3 while feeding continuously -> exactly S blocks accepted, then in_ready=0; out_block held stable; after release, all blocks drain in order with no loss or duplication.
- Flush: 5 blocks in flight, assert flush one cycle -> busy=0 next cycle, no out_valid for those blocks; next block yields the correct ciphertext at nominal latency.
- Reset mid-stream: reset_n low while 7 blocks are in flight -> out_valid=0, busy=0, in_ready=1 immediately. With ADAM_AES_STREAM_STATS_EN defined: counters 0 after reset; blk_in_cnt - blk_out_cnt equals the flushed count after the flush test.
